noc_ingress_router: RTL
=======================

NOC_INGRESS_ROUTER -- requirements
Module: noc_ingress_router

Interface
REQ-001 Parameter NODE_X, default 0: this node's 2-bit mesh X coordinate.
REQ-002 Parameter NODE_Y, default 0: this node's 2-bit mesh Y coordinate.
REQ-003 Parameter DEPTH, default 4: ingress FIFO depth in packets; power of two, 2..16.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 pkt_in  input  32: packet from the SPI gateway; [31:28] opcode, [23:22] target X, [21:20] target Y, [19:16] row address, [9:0] data.
REQ-007 pkt_valid  input  1: single-cycle strobe marking pkt_in valid (the gateway's ready pulse).
REQ-008 out_data  output  32: head-of-FIFO packet, shared by all output ports.
REQ-009 out_valid  output  5: one-hot port request; bit0 local, bit1 east, bit2 west, bit3 south, bit4 north.
REQ-010 out_ready  input  5: per-port accept, same bit order as out_valid.
REQ-011 overflow  output  1: sticky flag, set when a packet is dropped on a full FIFO.
REQ-012 drop_cnt  output  8: dropped-packet count (see Configuration).

Function
REQ-013 Opcode 4'h0 (NOP) packets shall be discarded at input, never enqueued, and never counted as drops.
REQ-014 A pkt_valid packet with a non-zero opcode shall be pushed when occupancy < DEPTH, or when occupancy = DEPTH and a pop occurs in the same cycle.
REQ-015 A push to a full FIFO with no same-cycle pop shall drop the packet, set overflow, and leave FIFO contents unchanged.
REQ-016 Routing shall be dimension-ordered XY on the head packet: X > NODE_X east; X < NODE_X west; X = NODE_X and Y > NODE_Y south; X = NODE_X and Y < NODE_Y north; both equal local.
REQ-017 out_valid shall be all-zero when the FIFO is empty and exactly one-hot otherwise.
REQ-018 out_data and out_valid shall be driven from registered FIFO state only; no combinational path from pkt_in, pkt_valid or out_ready.
REQ-019 A packet pushed into an empty FIFO at edge N shall appear on out_data/out_valid after edge N; one-cycle latency.
REQ-020 A pop shall occur on an edge where (out_valid & out_ready) != 0; ready on non-requested ports shall be ignored.
REQ-021 Once asserted, out_valid and out_data shall remain stable until the pop.
REQ-022 Read and write pointers shall wrap modulo DEPTH; occupancy shall run 0..DEPTH without aliasing full and empty.
REQ-023 Packets shall leave in arrival order across all ports (single FIFO, head-of-line blocking accepted).

Reset
REQ-024 While rst is high: FIFO empty, pointers 0, out_valid 0, out_data 32'h0, overflow 0, drop_cnt 0.
REQ-025 Reset asserted mid-transfer shall discard all queued packets immediately, with no partial pop completing.
REQ-026 A pkt_valid on the first edge after rst deasserts shall be accepted normally.

Configuration
REQ-027 Macro INGRESS_DROP_CNT_EN defined: drop_cnt increments by 1 per dropped packet and saturates at 8'hFF.
REQ-028 Macro INGRESS_DROP_CNT_EN undefined: drop_cnt is constant 8'h00, no counter logic exists, and overflow behaviour is unchanged.

Verification (NODE_X=1, NODE_Y=1, DEPTH=4)
REQ-029 Push 0x1050_0123 with out_ready=5'b00001 -> out_valid=5'b00001 next cycle, out_data=0x1050_0123, popped next edge, FIFO empty.
REQ-030 Push 0x10D0_0000, 0x1010_0000, 0x1060_0000 and 0x1040_0000 with out_ready=0 -> head out_valid=00010; granting each port in turn gives 00100, 01000 and 10000, in order.
REQ-031 Push 0x0050_0000 (NOP) -> out_valid stays 0, overflow 0, drop_cnt 0.
REQ-032 With out_ready=0, push 6 local packets -> first 4 retained, overflow=1, drop_cnt=2 with macro and 0 without; then draining yields the first 4 in order.
REQ-033 With FIFO full and the head being popped, push a 5th packet in the same cycle -> accepted, occupancy stays 4, overflow stays 0.
REQ-034 Assert rst with 3 packets queued while out_valid is high -> out_valid=0 asynchronously; after release the FIFO is empty, and a new push appears after 1 cycle.

Source files
------------

// File: rtl/noc_ingress_router.sv
// -----------------------------------------------------------------------------
// noc_ingress_router
//   Ingress stage of a 2D-mesh NoC node. Packets from the SPI gateway are
//   queued in a single in-order FIFO. The head packet is steered to one of
//   five output ports using dimension-ordered XY routing against this node's
//   (NODE_X, NODE_Y) coordinates.
//
// Parameters
//   NODE_X, NODE_Y : this node's 2-bit mesh coordinates
//   DEPTH          : FIFO depth in packets (power of two, 2..16)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   pkt_in     : [31:28] opcode, [23:22] target X, [21:20] target Y,
//                [19:16] row address, [9:0] data
//   pkt_valid  : single-cycle strobe qualifying pkt_in
//   out_data   : head-of-FIFO packet, shared by all output ports
//   out_valid  : one-hot port request {north, south, west, east, local}
//   out_ready  : per-port accept, same bit order as out_valid
//   overflow   : sticky flag, set when a packet is dropped on a full FIFO
//   drop_cnt   : saturating dropped-packet count
//
// Build option
//   INGRESS_DROP_CNT_EN : when defined, drop_cnt counts drops and saturates
//                         at 8'hFF. When undefined, drop_cnt is tied to 8'h00.
// -----------------------------------------------------------------------------
module noc_ingress_router #(
  parameter int unsigned NODE_X = 0,
  parameter int unsigned NODE_Y = 0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pkt_in,
  input  logic        pkt_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_valid,
  input  logic [4:0]  out_ready,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PORT_W = 5;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [3:0] OP_NOP = 4'h0;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 5'b00001;
  localparam logic [PORT_W-1:0] PORT_EAST  = 5'b00010;
  localparam logic [PORT_W-1:0] PORT_WEST  = 5'b00100;
  localparam logic [PORT_W-1:0] PORT_SOUTH = 5'b01000;
  localparam logic [PORT_W-1:0] PORT_NORTH = 5'b10000;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Registered head presentation
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [PORT_W-1:0] out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;

  logic pkt_real;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic [DATA_W-1:0] head_d;

  // XY routing decision for a given packet: X is resolved before Y
  function automatic logic [PORT_W-1:0] route(input logic [DATA_W-1:0] p);
    logic [1:0] tx;
    logic [1:0] ty;
    logic [PORT_W-1:0] r;
    tx = p[23:22];
    ty = p[21:20];
    if (tx > 2'(NODE_X)) begin
      r = PORT_EAST;
    end else if (tx < 2'(NODE_X)) begin
      r = PORT_WEST;
    end else if (ty > 2'(NODE_Y)) begin
      r = PORT_SOUTH;
    end else if (ty < 2'(NODE_Y)) begin
      r = PORT_NORTH;
    end else begin
      r = PORT_LOCAL;
    end
    return r;
  endfunction

  // Push/pop/drop qualification
  always_comb begin
    pkt_real = pkt_valid && (pkt_in[31:28] != OP_NOP);
    full     = (cnt_q == CNT_W'(DEPTH));
    // out_valid_q is only non-zero while the FIFO holds a packet, and only
    // the requested port's ready bit can complete a pop.
    pop      = |(out_valid_q & out_ready);
    // A full FIFO still accepts when the head leaves on the same edge.
    push     = pkt_real && (!full || pop);
    drop     = pkt_real && full && !pop;
  end

  // Next pointer/occupancy and next head presentation
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    head_d      = '0;
    out_data_d  = '0;
    out_valid_d = '0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end

    // When the packet being written becomes the sole entry, it is the next
    // head and has not reached storage yet, so bypass it from pkt_in.
    if (push && (cnt_d == CNT_W'(1))) begin
      head_d = pkt_in;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    if (cnt_d != '0) begin
      out_data_d  = head_d;
      out_valid_d = route(head_d);
    end
  end

  // FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= pkt_in;
    end
  end

  // Pointers, occupancy, head registers and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

`ifdef INGRESS_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule
